// File: rtl/fc_seq_pkg.sv
// Shared types and defaults for the FC-layer loop sequencer
// and the stall watchdog it instantiates.
package fc_seq_pkg;

   localparam int IDX_W = 8;

   localparam int DEF_MAX_IN     = 120;
   localparam int DEF_MAX_OUT    = 84;
   localparam int DEF_AW         = 16;
   localparam int DEF_MAC_LAT    = 3;
   localparam int DEF_WD_TIMEOUT = 1024;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      EMIT,
      DONE
   } state_t;

endpackage

// File: rtl/fc_loop_sequencer_if.sv
// Control, buffer-issue and result-stream bundle of the
// FC-layer loop sequencer.
interface fc_loop_sequencer_if
   import fc_seq_pkg::*;
#(
   parameter int AW = DEF_AW
);

   logic          start;
   idx_t          n_in;
   idx_t          n_out;
   logic          busy;
   logic          done;
   logic          rd_en;
   idx_t          x_addr;
   logic [AW-1:0] w_addr;
   logic          acc_clr;
   logic          acc_en;
   logic          out_valid;
   logic          out_ready;
   idx_t          out_idx;
   logic          block;

   modport master (
      input  start, n_in, n_out, out_ready,
      output busy, done, rd_en, x_addr, w_addr,
      output acc_clr, acc_en, out_valid, out_idx, block
   );

   modport slave (
      output start, n_in, n_out, out_ready,
      input  busy, done, rd_en, x_addr, w_addr,
      input  acc_clr, acc_en, out_valid, out_idx, block
   );

endinterface

// File: rtl/fc_stall_watchdog.sv
// Saturating stall counter with a sticky block flag; shared by
// the layer sequencers' deadlock monitors.
module fc_stall_watchdog
   import fc_seq_pkg::*;
#(
   parameter int TIMEOUT = DEF_WD_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic stall,
   input  logic clear,
   output logic block
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);

   // Count consecutive stall cycles; any gap in stalling is a
   // handshake, so the count restarts while the flag persists.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         block <= 1'b0;
      end else if (clear) begin
         cnt   <= '0;
         block <= 1'b0;
      end else if (stall) begin
         cnt <= cnt_inc;
         if (cnt_inc == CW'(TIMEOUT))
            block <= 1'b1;
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/fc_loop_sequencer.sv
// Output-neuron x input-element loop sequencer for the FC layer:
// issues buffer reads/MAC control and streams one result per neuron.
module fc_loop_sequencer
   import fc_seq_pkg::*;
#(
   parameter int MAX_IN     = DEF_MAX_IN,
   parameter int MAX_OUT    = DEF_MAX_OUT,
   parameter int AW         = DEF_AW,
   parameter int MAC_LAT    = DEF_MAC_LAT,
   parameter int WD_TIMEOUT = DEF_WD_TIMEOUT
) (
   input  logic                clock,
   input  logic                reset,
   fc_loop_sequencer_if.master bus
);

   localparam int DW = $clog2(MAC_LAT + 1);

   if (MAX_IN * MAX_OUT > 2 ** AW) begin : g_cfg_err
      $error("weight address space too small for MAX_IN*MAX_OUT");
   end

   if (MAC_LAT < 1) begin : g_lat_err
      $error("MAC_LAT must be at least 1");
   end

   state_t        state;
   state_t        state_nx;
   idx_t          n_in_q;
   idx_t          n_out_q;
   idx_t          i_q;
   idx_t          j_q;
   logic [AW-1:0] w_base;
   logic [DW-1:0] drain_cnt;
   logic          zero_len;
   logic          last_j;
   logic          last_i;
   logic          accept;
   logic          stall;

   assign zero_len = (bus.n_in == '0) || (bus.n_out == '0);
   assign last_j   = (j_q == n_in_q - idx_t'(1));
   assign last_i   = (i_q == n_out_q - idx_t'(1));
   assign accept   = (state == IDLE) && bus.start;
   assign stall    = (state == EMIT) && !bus.out_ready;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state decode for the loop nest.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (bus.start)
               state_nx = zero_len ? DONE : RUN;
         RUN:
            if (last_j)
               state_nx = DRAIN;
         DRAIN:
            if (drain_cnt == '0)
               state_nx = EMIT;
         EMIT:
            if (bus.out_ready)
               state_nx = last_i ? DONE : RUN;
         DONE:
            state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   // Loop indices and running weight base; w_base steps by n_in
   // per neuron so no multiplier is needed for i*n_in.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         n_in_q    <= '0;
         n_out_q   <= '0;
         i_q       <= '0;
         j_q       <= '0;
         w_base    <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE:
               if (bus.start) begin
                  n_in_q  <= bus.n_in;
                  n_out_q <= bus.n_out;
                  i_q     <= '0;
                  j_q     <= '0;
                  w_base  <= '0;
               end
            RUN:
               if (last_j)
                  drain_cnt <= DW'(MAC_LAT - 1);
               else
                  j_q <= j_q + idx_t'(1);
            DRAIN:
               if (drain_cnt != '0)
                  drain_cnt <= drain_cnt - DW'(1);
            EMIT:
               if (bus.out_ready && !last_i) begin
                  i_q    <= i_q + idx_t'(1);
                  j_q    <= '0;
                  w_base <= w_base + AW'(n_in_q);
               end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.rd_en     = (state == RUN);
   assign bus.acc_en    = (state == RUN);
   assign bus.acc_clr   = (state == RUN) && (j_q == '0);
   assign bus.x_addr    = j_q;
   assign bus.w_addr    = w_base + AW'(j_q);
   assign bus.out_valid = (state == EMIT);
   assign bus.out_idx   = i_q;

   fc_stall_watchdog #(
      .TIMEOUT (WD_TIMEOUT)
   ) u_wd (
      .clock (clock),
      .reset (reset),
      .stall (stall),
      .clear (accept),
      .block (bus.block)
   );

endmodule

// File: doc/fc_loop_sequencer.md
# fc_loop_sequencer

Control FSM for the fully-connected layer datapath of the LeNet-5 accelerator. It sequences the two-level output-neuron × input-element loop nest, driving read addresses and MAC control into the weight/activation buffers and accumulator. Each finished neuron is emitted through a valid/ready stream. A stall watchdog on that stream raises a sticky `block` flag, which feeds the design's deadlock-monitor tree.

## Interface
Parameters:
- `MAX_IN`, 120: largest supported input length.
- `MAX_OUT`, 84: largest supported output length.
- `AW`, 16: weight address width; must satisfy MAX_IN*MAX_OUT ≤ 2^AW.
- `MAC_LAT`, 3: cycles from last MAC issue to accumulator result valid (≥1).
- `WD_TIMEOUT`, 1024: stall cycles before `block` asserts.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: begin layer; sampled only in IDLE.
- `n_in`, in, 8: input length, latched on accepted start.
- `n_out`, in, 8: output length, latched on accepted start.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at layer completion.
- `rd_en`, out, 1: buffer read strobe.
- `x_addr`, out, 8: activation address j.
- `w_addr`, out, AW: weight address i*n_in + j.
- `acc_clr`, out, 1: accumulator clear, coincident with j==0 issue.
- `acc_en`, out, 1: MAC enable, equal to rd_en.
- `out_valid`, out, 1: result stream valid.
- `out_ready`, in, 1: result stream ready.
- `out_idx`, out, 8: neuron index i of the presented result.
- `block`, out, 1: watchdog stall flag, sticky.

## Operation
- States: IDLE, RUN, DRAIN, EMIT, DONE.
- IDLE → RUN on `start` when n_in≠0 and n_out≠0. Latch both values and clear i, j, w_base, wd_cnt and `block`.
- IDLE → DONE on `start` when n_in==0 or n_out==0. No reads are issued.
- RUN: rd_en=acc_en=1 every cycle.
  - x_addr=j; w_addr=w_base+j. w_base is a running sum; no multiplier.
  - acc_clr=1 when j==0.
  - When j==n_in−1, go to DRAIN and load drain_cnt=MAC_LAT−1.
- DRAIN: no issue. Decrement drain_cnt; at 0 go to EMIT.
- EMIT: out_valid=1, out_idx=i.
  - On out_ready with i==n_out−1, go to DONE.
  - On out_ready otherwise: i+=1, j=0, w_base+=n_in, go to RUN.
- DONE: done=1 for one cycle, then → IDLE.
- `start` is ignored outside IDLE; n_in and n_out changes outside IDLE have no effect.
- Watchdog:
  - In EMIT with out_ready=0, wd_cnt increments and saturates. On reaching WD_TIMEOUT, `block` sets.
  - wd_cnt clears on every handshake.
  - `block` clears only on reset or on an accepted start.
- Width rules: j and i are 8-bit. w_addr arithmetic is AW bits, unsigned. Behaviour with n_in>MAX_IN or n_out>MAX_OUT is unspecified.

## Timing
- All outputs are registered or decoded from registered state.
- Reset values: busy, done, rd_en, acc_en, acc_clr, out_valid and block are 0; x_addr, w_addr and out_idx are 0. State is IDLE.
- `start` sampled at cycle t → first rd_en at t+1.
- With out_ready held high: each neuron takes n_in + MAC_LAT + 1 cycles, and done is high at cycle t+1+n_out*(n_in+MAC_LAT+1).
- Zero-length start at t → done at t+1.
- out_valid, once high, holds with a stable out_idx until the handshake.
- Async reset mid-layer: immediate return to IDLE with reset values. No done pulse and no partial-result emission.

## Structure
- Package `fc_seq_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, EMIT, DONE);
  - index width (8);
  - default values of MAX_IN, MAX_OUT, AW, MAC_LAT and WD_TIMEOUT.
- Sub-module `fc_stall_watchdog` contains the saturating counter plus sticky flag.
  - Inputs: stall, clear.
  - Output: block.
  - Reused by other layer sequencers.

## Test plan
- n_in=4, n_out=3, MAC_LAT=3, out_ready=1:
  - w_addr runs 0..11 in three 4-cycle bursts;
  - acc_clr appears at w_addr 0, 4, 8;
  - out_idx goes 0, 1, 2;
  - done is high exactly 25 cycles after start.
- Backpressure: n_in=2, n_out=2, out_ready low for 5 cycles in the first EMIT → out_valid and out_idx=0 hold for 6 cycles, no rd_en during the stall, total latency +5.
- Watchdog: WD_TIMEOUT=8, out_ready held 0 → block rises after 8 stall cycles and stays high after a later handshake; the next start clears it.
- Zero length: n_in=0, n_out=5 → no rd_en, done pulse one cycle after start.
- start pulsed while busy → ignored; the sequence and done timing are unchanged.
- Reset asserted asynchronously during the second RUN burst → all outputs go to reset values before the next edge, no done pulse; a fresh start runs correctly from i=0.
